// File: rtl/ysyx_041461_if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: trap codes, FSM state
// encodings and small helpers used by the stage and its holding buffer.
// No logic lives here; everything is constants, types and pure functions.
package ysyx_041461_if_stage_pkg;

    localparam int unsigned TRAP_W = 4;
    localparam int unsigned INST_W = 32;

    // Trap codes carried alongside each fetched instruction.
    localparam logic [TRAP_W-1:0] TRAP_NOP               = 4'd0;
    localparam logic [TRAP_W-1:0] TRAP_INST_MISALIGN     = 4'd1;
    localparam logic [TRAP_W-1:0] TRAP_INST_ACCESS_FAULT = 4'd2;

    // Fetch FSM states.
    //   IF_REQ   : present a request for pc (or flag a misaligned pc)
    //   IF_WAIT  : one request outstanding, waiting for its response
    //   IF_DRAIN : an orphaned request is outstanding after a redirect
    //   IF_STOP  : a fetch trap was raised; idle until redirected
    typedef enum logic [1:0] {
        IF_REQ   = 2'd0,
        IF_WAIT  = 2'd1,
        IF_DRAIN = 2'd2,
        IF_STOP  = 2'd3
    } if_state_e;

    // Instructions are 32-bit aligned; any set low bit is a misaligned fetch.
    function automatic logic pc_misaligned(input logic [1:0] pc_lo);
        return pc_lo != 2'b00;
    endfunction

endpackage

// File: rtl/ysyx_041461_if_outbuf.sv
// One-entry holding register between fetch and the ID pipeline register.
// Latency: entry visible the cycle after load; consumed at any edge with consume=1.
// Backpressure: entry holds while consume=0; flush invalidates regardless of consume.
module ysyx_041461_if_outbuf
    import ysyx_041461_if_stage_pkg::*;
#(
    parameter int unsigned          ADDR_W   = 64,
    parameter logic [ADDR_W-1:0]    RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_vld,
    input  logic [TRAP_W-1:0]   load_trap,
    input  logic [INST_W-1:0]   load_inst,
    input  logic [ADDR_W-1:0]   load_pc,
    input  logic                consume,
    input  logic                flush,
    output logic                out_vld,
    output logic [TRAP_W-1:0]   out_trap,
    output logic [INST_W-1:0]   out_inst,
    output logic [ADDR_W-1:0]   out_pc
);

    logic                valid_q, valid_d;
    logic [TRAP_W-1:0]   trap_q,  trap_d;
    logic [INST_W-1:0]   inst_q,  inst_d;
    logic [ADDR_W-1:0]   pc_q,    pc_d;

    // Entry update: flush beats load, load beats consume. A load in the same
    // cycle as a consume refills the entry, so valid stays high. Payload fields
    // are left alone on consume/flush; only valid qualifies them downstream.
    always_comb begin
        valid_d = valid_q;
        trap_d  = trap_q;
        inst_d  = inst_q;
        pc_d    = pc_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load_vld) begin
            valid_d = 1'b1;
            trap_d  = load_trap;
            inst_d  = load_inst;
            pc_d    = load_pc;
        end else if (consume) begin
            valid_d = 1'b0;
        end
    end

    // Entry storage with asynchronous reset to an empty, trap-free entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            trap_q  <= TRAP_NOP;
            inst_q  <= '0;
            pc_q    <= RESET_PC;
        end else begin
            valid_q <= valid_d;
            trap_q  <= trap_d;
            inst_q  <= inst_d;
            pc_q    <= pc_d;
        end
    end

    assign out_vld  = valid_q;
    assign out_trap = trap_q;
    assign out_inst = inst_q;
    assign out_pc   = pc_q;

endmodule

// File: rtl/ysyx_041461_if_stage.sv
// Instruction fetch: PC generation, single-outstanding imem requests, IF->ID handoff.
// Latency: request -> response (>=1 cycle) -> entry presented the following cycle; best 1 inst / 2 cycles.
// Backpressure: new requests issue only when the output entry is free or being consumed (id_ready).
module ysyx_041461_if_stage
    import ysyx_041461_if_stage_pkg::*;
#(
    parameter int unsigned          ADDR_W   = 64,
    parameter logic [ADDR_W-1:0]    RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_ready,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [ADDR_W-1:0]   imem_req_addr,
    input  logic                imem_resp_valid,
    input  logic [INST_W-1:0]   imem_resp_data,
    input  logic                imem_resp_err,
    output logic                if_valid_out,
    output logic [TRAP_W-1:0]   if_trap_out,
    output logic [INST_W-1:0]   if_inst_out,
    output logic [ADDR_W-1:0]   if_pc_out
);

    if_state_e           state_q, state_d;
    logic [ADDR_W-1:0]   pc_q,    pc_d;

    logic                buf_free;
    logic                pc_misalign;
    logic                req_fire;
    logic                req_pending_after;
    logic                buf_load;
    logic [TRAP_W-1:0]   load_trap;
    logic [INST_W-1:0]   load_inst;

    // The entry can accept new data if it is empty or leaves this cycle.
    assign buf_free    = !if_valid_out || id_ready;
    assign pc_misalign = pc_misaligned(pc_q[1:0]);
    assign req_fire    = imem_req_valid && imem_req_ready;

    // A request stays in flight past this cycle if we were waiting and nothing
    // came back, or a new request was just accepted.
    assign req_pending_after =
        ((state_q == IF_WAIT)  && !imem_resp_valid) ||
        ((state_q == IF_DRAIN) && !imem_resp_valid) ||
        ((state_q == IF_REQ)   && req_fire);

    // State and PC registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IF_REQ;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Next state and next PC; a redirect overrides everything else and either
    // drains an orphaned request or restarts fetch immediately.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (redirect_valid) begin
            pc_d    = redirect_pc;
            state_d = req_pending_after ? IF_DRAIN : IF_REQ;
        end else begin
            case (state_q)
                IF_REQ: begin
                    if (pc_misalign) begin
                        if (buf_free) begin
                            state_d = IF_STOP;
                        end
                    end else if (req_fire) begin
                        state_d = IF_WAIT;
                    end
                end
                IF_WAIT: begin
                    if (imem_resp_valid) begin
                        if (imem_resp_err) begin
                            state_d = IF_STOP;
                        end else begin
                            pc_d    = pc_q + ADDR_W'(4);
                            state_d = IF_REQ;
                        end
                    end
                end
                IF_DRAIN: begin
                    if (imem_resp_valid) begin
                        state_d = IF_REQ;
                    end
                end
                IF_STOP: begin
                    state_d = IF_STOP;
                end
                default: begin
                    state_d = IF_REQ;
                end
            endcase
        end
    end

    // Outputs: request handshake and the buffer write. The request is held low
    // while reset is asserted so nothing escapes before the FSM is running;
    // a redirect cycle never writes the buffer (any response is dropped).
    always_comb begin
        imem_req_valid = rst && (state_q == IF_REQ) && !pc_misalign && buf_free;
        buf_load       = 1'b0;
        load_trap      = TRAP_NOP;
        load_inst      = '0;
        if (!redirect_valid) begin
            case (state_q)
                IF_REQ: begin
                    if (pc_misalign && buf_free) begin
                        buf_load  = 1'b1;
                        load_trap = TRAP_INST_MISALIGN;
                    end
                end
                IF_WAIT: begin
                    if (imem_resp_valid) begin
                        buf_load  = 1'b1;
                        load_trap = imem_resp_err ? TRAP_INST_ACCESS_FAULT : TRAP_NOP;
                        load_inst = imem_resp_data;
                    end
                end
                default: begin
                    buf_load = 1'b0;
                end
            endcase
        end
    end

    assign imem_req_addr = pc_q;

    ysyx_041461_if_outbuf #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_outbuf (
        .clk       (clk),
        .rst       (rst),
        .load_vld  (buf_load),
        .load_trap (load_trap),
        .load_inst (load_inst),
        .load_pc   (pc_q),
        .consume   (id_ready),
        .flush     (redirect_valid),
        .out_vld   (if_valid_out),
        .out_trap  (if_trap_out),
        .out_inst  (if_inst_out),
        .out_pc    (if_pc_out)
    );

endmodule

// File: tb/tb_ysyx_041461_if_stage.sv
// Scoreboard bench for the fetch stage: a memory model answers accepted
// requests, expected request addresses and IF->ID entries are queued by the
// stimulus and checked by a negedge monitor as the DUT produces them.
module tb_ysyx_041461_if_stage;
    import ysyx_041461_if_stage_pkg::*;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    typedef struct packed {
        logic [3:0]  trap;
        logic [31:0] inst;
        logic [63:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        id_ready = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        imem_resp_err = 1'b0;
    logic        if_valid_out;
    logic [3:0]  if_trap_out;
    logic [31:0] if_inst_out;
    logic [63:0] if_pc_out;

    int checks = 0;
    int failures = 0;

    logic [63:0] exp_req[$];
    exp_t        exp_out[$];

    // memory model state
    int          acc_seq = 0;      // written by monitor only
    logic [63:0] acc_addr = '0;    // written by monitor only
    int          seen_seq = 0;
    int          grant_limit = 0;
    int          resp_cnt = 0;
    int          mem_lat = 1;
    logic [63:0] resp_addr = '0;
    logic [63:0] err_addr = 64'h0000_0000_8000_0010;

    ysyx_041461_if_stage dut (
        .clk             (clk),
        .rst             (rst),
        .id_ready        (id_ready),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .imem_resp_err   (imem_resp_err),
        .if_valid_out    (if_valid_out),
        .if_trap_out     (if_trap_out),
        .if_inst_out     (if_inst_out),
        .if_pc_out       (if_pc_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        if (a == 64'h0000_0000_8000_0040) return 32'hDEAD_BEEF;
        return a[31:0] ^ 32'h1234_5678;
    endfunction

    function automatic exp_t mk(input logic [3:0] t, input logic [31:0] i, input logic [63:0] p);
        exp_t e;
        e.trap = t; e.inst = i; e.pc = p;
        return e;
    endfunction

    task automatic push_ok(input logic [63:0] a);
        exp_out.push_back(mk(TRAP_NOP, inst_of(a), a));
    endtask

    task automatic upd_ready();
        imem_req_ready = (acc_seq < grant_limit);
    endtask

    // One clock: inputs change 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        imem_resp_valid = 1'b0;
        imem_resp_err   = 1'b0;
        imem_resp_data  = '0;
        if (!rst) begin
            resp_cnt = 0;
            seen_seq = acc_seq;
        end else begin
            if (seen_seq != acc_seq) begin
                seen_seq  = acc_seq;
                resp_addr = acc_addr;
                resp_cnt  = mem_lat;
            end
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data  = inst_of(resp_addr);
                    imem_resp_err   = (resp_addr == err_addr);
                end
            end
        end
        upd_ready();
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_acc(input int n);
        int k = 0;
        while (seen_seq < n && k < 40) begin
            tick();
            k++;
        end
        chk("wait_accept", 64'(seen_seq), 64'(n));
    endtask

    task automatic redirect_to(input logic [63:0] a);
        redirect_valid = 1'b1;
        redirect_pc    = a;
        tick();
        redirect_valid = 1'b0;
    endtask

    // Monitor: request handshakes and IF->ID transfers against the queues.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                if (imem_req_valid && imem_req_ready) begin
                    acc_seq++;
                    acc_addr = imem_req_addr;
                    if (exp_req.size() == 0) chk("req_unexpected", 64'(exp_req.size()), 64'd1);
                    else chk("req_addr", imem_req_addr, exp_req.pop_front());
                end
                if (if_valid_out && id_ready) begin
                    if (exp_out.size() == 0) begin
                        chk("out_unexpected_pc", 64'(exp_out.size()), 64'd1);
                    end else begin
                        exp_t e;
                        e = exp_out.pop_front();
                        chk("out_pc",   if_pc_out,   e.pc);
                        chk("out_inst", 64'(if_inst_out), 64'(e.inst));
                        chk("out_trap", 64'(if_trap_out), 64'(e.trap));
                    end
                end
            end
        end
    end

    initial begin
        // reset state
        repeat (3) tick();
        at_neg();
        chk("rst_valid", 64'(if_valid_out), 64'd0);
        chk("rst_trap",  64'(if_trap_out),  64'(TRAP_NOP));
        chk("rst_inst",  64'(if_inst_out),  64'd0);
        chk("rst_pc",    if_pc_out,         RST_PC);
        chk("rst_req",   64'(imem_req_valid), 64'd0);

        // sequential fetch, 1-cycle memory
        tick();
        for (int i = 0; i < 3; i++) begin
            exp_req.push_back(RST_PC + 64'(4 * i));
            push_ok(RST_PC + 64'(4 * i));
        end
        rst = 1'b1;
        grant_limit = 3;
        upd_ready();
        wait_acc(3);
        tick();
        tick();

        // hold under id_ready=0, then access fault at 0x8000_0010
        id_ready = 1'b0;
        exp_req.push_back(64'h8000_000C);
        exp_req.push_back(64'h8000_0010);
        push_ok(64'h8000_000C);
        exp_out.push_back(mk(TRAP_INST_ACCESS_FAULT, inst_of(64'h8000_0010), 64'h8000_0010));
        grant_limit = 5;
        upd_ready();
        wait_acc(4);
        tick();
        for (int i = 0; i < 5; i++) begin
            at_neg();
            chk("hold_valid", 64'(if_valid_out), 64'd1);
            chk("hold_pc",    if_pc_out, 64'h8000_000C);
            chk("hold_req",   64'(imem_req_valid), 64'd0);
            tick();
        end
        id_ready = 1'b1;
        at_neg();
        chk("resume_req_vld",  64'(imem_req_valid), 64'd1);
        chk("resume_req_addr", imem_req_addr, 64'h8000_0010);
        wait_acc(5);
        tick();
        grant_limit = 6;
        upd_ready();
        repeat (3) tick();
        at_neg();
        chk("stop_after_fault_req", 64'(imem_req_valid), 64'd0);
        tick();

        // redirect in WAIT; stale response must be dropped
        exp_req.push_back(64'h8000_0040);
        exp_req.push_back(64'h8000_0100);
        push_ok(64'h8000_0100);
        grant_limit = 7;
        mem_lat = 3;
        redirect_to(64'h8000_0040);
        wait_acc(6);
        mem_lat = 1;
        redirect_to(64'h8000_0100);
        at_neg();
        chk("drain_req",   64'(imem_req_valid), 64'd0);
        chk("drain_valid", 64'(if_valid_out), 64'd0);
        wait_acc(7);

        // redirect coinciding with a response: direct restart at 0x180
        exp_req.push_back(64'h8000_0104);
        exp_req.push_back(64'h8000_0180);
        push_ok(64'h8000_0180);
        grant_limit = 9;
        upd_ready();
        tick();
        wait_acc(8);
        chk("redir_resp_same_cycle", 64'(imem_resp_valid), 64'd1);
        redirect_to(64'h8000_0180);
        at_neg();
        chk("restart_req_vld",  64'(imem_req_valid), 64'd1);
        chk("restart_req_addr", imem_req_addr, 64'h8000_0180);
        wait_acc(9);
        tick();
        tick();

        // misaligned redirect -> trap entry, STOP until redirected
        exp_out.push_back(mk(TRAP_INST_MISALIGN, 32'h0, 64'h8000_0102));
        redirect_to(64'h8000_0102);
        grant_limit = 10;
        upd_ready();
        at_neg();
        chk("misalign_req", 64'(imem_req_valid), 64'd0);
        repeat (4) tick();
        at_neg();
        chk("stop_req",   64'(imem_req_valid), 64'd0);
        chk("stop_valid", 64'(if_valid_out), 64'd0);
        tick();

        // leave STOP, then reset in the middle of WAIT
        exp_req.push_back(64'h8000_0200);
        mem_lat = 3;
        redirect_to(64'h8000_0200);
        wait_acc(10);
        mem_lat = 1;
        @(negedge clk);
        rst = 1'b0;
        resp_cnt = 0;
        #1;
        chk("arst_valid", 64'(if_valid_out), 64'd0);
        chk("arst_trap",  64'(if_trap_out),  64'(TRAP_NOP));
        chk("arst_inst",  64'(if_inst_out),  64'd0);
        chk("arst_pc",    if_pc_out,         RST_PC);
        chk("arst_req",   64'(imem_req_valid), 64'd0);
        tick();
        tick();

        // restart at RESET_PC with entry held; redirect flushes it anyway
        id_ready = 1'b0;
        exp_req.push_back(RST_PC);
        rst = 1'b1;
        grant_limit = 11;
        upd_ready();
        wait_acc(11);
        tick();
        at_neg();
        chk("refetch_valid", 64'(if_valid_out), 64'd1);
        chk("refetch_pc",    if_pc_out, RST_PC);
        chk("refetch_inst",  64'(if_inst_out), 64'(inst_of(RST_PC)));
        tick();

        // flush while stalled, then PC wraps from the top of the address space
        exp_req.push_back(64'hFFFF_FFFF_FFFF_FFFC);
        exp_req.push_back(64'h0);
        push_ok(64'hFFFF_FFFF_FFFF_FFFC);
        push_ok(64'h0);
        redirect_to(64'hFFFF_FFFF_FFFF_FFFC);
        grant_limit = 13;
        upd_ready();
        at_neg();
        chk("flush_stalled_valid", 64'(if_valid_out), 64'd0);
        tick();
        id_ready = 1'b1;
        wait_acc(13);
        repeat (4) tick();

        chk("exp_req_left", 64'(exp_req.size()), 64'd0);
        chk("exp_out_left", 64'(exp_out.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/ysyx_041461_if_stage.md
Name: ysyx_041461_if_stage

Overview:
- Instruction-fetch stage of the in-order RV64 pipeline; producer side of the IF→ID pipeline-register interface.
- Generates the PC and issues single-outstanding 32-bit fetches on a valid/ready instruction-memory port.
- Presents {valid, trap, inst, pc} to the ID register and holds it until ID's load enable accepts it.
- Supports redirect (branch/jump/trap entry) with discard of any in-flight fetch.

Parameters:
RESET_PC, 64'h0000_0000_8000_0000, PC of first fetch after reset
ADDR_W, 64, PC/address width

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset (0 = reset asserted)
id_ready  in  1  ID register load enable; held entry transfers in a cycle with id_ready=1
redirect_valid  in  1  flush and restart fetch at redirect_pc
redirect_pc  in  64  new fetch PC
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  64  fetch address
imem_resp_valid  in  1  response valid; always accepted
imem_resp_data  in  32  fetched instruction
imem_resp_err  in  1  access fault on this response
if_valid_out  out  1  to IDreg_valid_in
if_trap_out  out  4  to IDreg_trap_in
if_inst_out  out  32  to IDreg_inst_in
if_pc_out  out  64  to IDreg_pc_in

Behaviour:
- Reset (rst=0, async): state=REQ, pc=RESET_PC, if_valid_out=0, if_trap_out=TRAP_NOP, if_inst_out=0, if_pc_out=RESET_PC, imem_req_valid=0.
- Output buffer: one entry. Consumed in any cycle with id_ready=1. The entry is cleared to valid=0 on consumption unless it is refilled in the same cycle. When id_ready=0, all outputs hold.
- buf_free = !if_valid_out | id_ready.
- States: REQ, WAIT, DRAIN, STOP.
- REQ:
  - If pc[1:0]!=0: no request is issued. When buf_free, write entry {1, TRAP_INST_MISALIGN, 0, pc}, then go to STOP.
  - Otherwise imem_req_valid = buf_free, with imem_req_addr=pc. On valid&ready, go to WAIT.
  - imem_req_valid depends only on state, pc and buf_free. It does not depend on imem_req_ready.
- WAIT: on imem_resp_valid:
  - Write entry {1, err?TRAP_INST_ACCESS_FAULT:TRAP_NOP, data, pc}. The buffer is guaranteed free here, because a request is issued only when buf_free.
  - If err=0: pc<=pc+4 (wraps mod 2^64) and go to REQ.
  - If err=1: go to STOP.
- STOP: no requests are issued; the entry is held until consumed; only a redirect leaves this state.
- DRAIN: wait for the orphan response, which is discarded (no buffer write), then go to REQ.
- Redirect (highest priority, any state):
  - pc<=redirect_pc; the buffer entry is invalidated that cycle, even if id_ready=0.
  - Next state is DRAIN if a request is outstanding after this cycle, i.e. (WAIT & !imem_resp_valid), or (REQ & req handshake this cycle), or (DRAIN & !imem_resp_valid).
  - Otherwise the next state is REQ.
  - A response arriving in the redirect cycle is dropped.
- The memory returns responses in order, with at most one outstanding request; zero-cycle (same-cycle) responses are not permitted.
- Throughput: at best one instruction every 2 cycles.

Decomposition:
- Shared macro file holds TRAP_NOP (existing), TRAP_INST_MISALIGN=4'd1, TRAP_INST_ACCESS_FAULT=4'd2, and the state encodings.
- Natural sub-module: ysyx_041461_if_outbuf, the one-entry holding buffer with load/consume/flush.
- FSM and PC logic stay in the top module.

Test Plan:
- Reset release, memory always ready, 1-cycle response latency, id_ready=1 → requests at 0x8000_0000, 0x8000_0004, 0x8000_0008; each if_valid_out pulse carries the matching pc/inst and TRAP_NOP.
- id_ready=0 for 5 cycles while an entry is held → outputs stable and imem_req_valid=0; after id_ready returns to 1, the next request appears in that same cycle.
- Redirect to 0x8000_0100 while in WAIT; stale response 0xDEAD_BEEF arrives 2 cycles later → it is never presented. The next request address is 0x8000_0100.
- Redirect in the same cycle as an imem_resp_valid → the response is dropped, the state goes directly to REQ, and the request is issued at the redirect pc.
- Redirect to 0x8000_0102 → no memory request; entry {1, TRAP_INST_MISALIGN, 0, 0x8000_0102}; stays in STOP until redirect to 0x8000_0200.
- Response with imem_resp_err=1 at pc 0x8000_0010 → entry trap=TRAP_INST_ACCESS_FAULT, no further fetches; assert rst=0 mid-WAIT → outputs immediately return to reset values, and fetch restarts at RESET_PC.
